net_resolver: RTL

- Parametrised, clocked resolver for multi-driven 4-state nets.
- Takes NUM_DRV drivers of WIDTH bits each and resolves them per bit under a runtime-selected net kind: wire, wand, wor, tri0, tri1, trireg, supply0 or supply1.
- Registers the resolved value and adds trireg charge retention with decay.
- Counts beats on which drivers contend.
- Used by the simulator-reference model and by the generated-design checkers as the golden net-resolution engine.

---
 rtl/net_resolver_pkg.sv | 40 ++++
 rtl/net_resolver_bit.sv | 84 ++++++++
 rtl/net_resolver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/net_resolver_pkg.sv
// Shared types for the net resolver: 4-state encoding, net kinds and the
// pairwise wire join used when folding drivers.
package net_resolver_pkg;

    // 4-state value packed as {unk, val}
    typedef logic [1:0] logic4_t;

    localparam logic4_t L0 = 2'b00;
    localparam logic4_t L1 = 2'b01;
    localparam logic4_t LZ = 2'b10;
    localparam logic4_t LX = 2'b11;

    typedef enum logic [2:0] {
        WIRE   = 3'd0,
        WAND   = 3'd1,
        WOR    = 3'd2,
        TRI0   = 3'd3,
        TRI1   = 3'd4,
        TRIREG = 3'd5,
        SUP0   = 3'd6,
        SUP1   = 3'd7
    } net_kind_e;

    // Wire join of two drivers: z yields to the other side, x dominates,
    // and disagreeing strong values collapse to x.
    function automatic logic4_t resolve_wire(logic4_t a, logic4_t b);
        logic4_t r;
        if (a == LZ) begin
            r = b;
        end else if (b == LZ) begin
            r = a;
        end else if (a == LX || b == LX || a != b) begin
            r = LX;
        end else begin
            r = a;
        end
        return r;
    endfunction

endpackage

// File: rtl/net_resolver_bit.sv
// Combinational fold of all drivers of one net bit under a net kind.
// Also reports the plain wire value and the all-z flag that the top uses
// for trireg charge tracking, and whether 0 and 1 were both driven.
module net_resolve_bit
    import net_resolver_pkg::*;
#(
    parameter int NUM_DRV = 4
) (
    input  net_kind_e            kind,
    input  logic [NUM_DRV-1:0]   en,
    input  logic [NUM_DRV-1:0]   val,
    input  logic [NUM_DRV-1:0]   unk,
    input  logic4_t              charge,
    output logic4_t              res,
    output logic4_t              wire_res,
    output logic                 all_z,
    output logic                 contend
);

    logic4_t cur;
    logic4_t w;
    logic    has0;
    logic    has1;
    logic    hasx;

    // Scan the enabled drivers once, collecting the wire join and presence flags
    always_comb begin
        cur  = LZ;
        w    = LZ;
        has0 = 1'b0;
        has1 = 1'b0;
        hasx = 1'b0;
        for (int d = 0; d < NUM_DRV; d++) begin
            if (en[d]) begin
                cur = {unk[d], val[d]};
                w   = resolve_wire(w, cur);
                if (cur == L0) has0 = 1'b1;
                if (cur == L1) has1 = 1'b1;
                if (cur == LX) hasx = 1'b1;
            end
        end
    end

    // Apply the kind-specific rule on top of the collected flags
    always_comb begin
        wire_res = w;
        all_z    = (w == LZ);
        contend  = 1'b0;
        res      = w;
        case (kind)
            WAND: begin
                if (has0)      res = L0;
                else if (hasx) res = LX;
                else if (has1) res = L1;
                else           res = LZ;
            end
            WOR: begin
                if (has1)      res = L1;
                else if (hasx) res = LX;
                else if (has0) res = L0;
                else           res = LZ;
            end
            TRI0: begin
                res     = (w == LZ) ? L0 : w;
                contend = has0 & has1;
            end
            TRI1: begin
                res     = (w == LZ) ? L1 : w;
                contend = has0 & has1;
            end
            TRIREG: begin
                res     = (w == LZ) ? charge : w;
                contend = has0 & has1;
            end
            SUP0: res = L0;
            SUP1: res = L1;
            default: begin
                res     = w;
                contend = has0 & has1;
            end
        endcase
    end

endmodule

// File: rtl/net_resolver.sv
// Registered multi-driver net resolver with trireg charge retention/decay
// and a saturating contention-beat counter.
// Handshake: in_valid marks a beat; its result appears one edge later with
// out_valid high. There is no backpressure; when in_valid is low all
// outputs and internal charge state hold.
module net_resolver
    import net_resolver_pkg::*;
#(
    parameter int NUM_DRV      = 4,
    parameter int WIDTH        = 8,
    parameter int DECAY_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [2:0]                 kind,
    input  logic [NUM_DRV-1:0]         drv_en,
    input  logic [NUM_DRV*WIDTH-1:0]   drv_val,
    input  logic [NUM_DRV*WIDTH-1:0]   drv_unk,
    input  logic                       cnt_clr,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           res_val,
    output logic [WIDTH-1:0]           res_unk,
    output logic [WIDTH-1:0]           contend,
    output logic [CNT_W-1:0]           contend_cnt
);

    localparam int DW = (DECAY_CYCLES < 2) ? 1 : $clog2(DECAY_CYCLES + 1);
    localparam logic [DW-1:0] DECAY_MAX = DW'(DECAY_CYCLES);

    net_kind_e            kind_e;
    logic [NUM_DRV-1:0]   bit_val [WIDTH];
    logic [NUM_DRV-1:0]   bit_unk [WIDTH];
    logic4_t              bit_res [WIDTH];
    logic4_t              bit_wire [WIDTH];
    logic [WIDTH-1:0]     bit_allz;
    logic [WIDTH-1:0]     bit_contend;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     res_val_q, res_val_d;
    logic [WIDTH-1:0]     res_unk_q, res_unk_d;
    logic [WIDTH-1:0]     contend_q, contend_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic4_t              charge_q [WIDTH];
    logic4_t              charge_d [WIDTH];
    logic [DW-1:0]        decay_q [WIDTH];
    logic [DW-1:0]        decay_d [WIDTH];

    assign kind_e = net_kind_e'(kind);

    // Transpose the driver planes into per-bit driver vectors
    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            for (int d = 0; d < NUM_DRV; d++) begin
                bit_val[b][d] = drv_val[d*WIDTH + b];
                bit_unk[b][d] = drv_unk[d*WIDTH + b];
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        net_resolve_bit #(.NUM_DRV(NUM_DRV)) u_bit (
            .kind     (kind_e),
            .en       (drv_en),
            .val      (bit_val[g]),
            .unk      (bit_unk[g]),
            .charge   (charge_q[g]),
            .res      (bit_res[g]),
            .wire_res (bit_wire[g]),
            .all_z    (bit_allz[g]),
            .contend  (bit_contend[g])
        );
    end

    // Next-state: outputs, charge/decay and contention counter
    always_comb begin
        out_valid_d = 1'b0;
        res_val_d   = res_val_q;
        res_unk_d   = res_unk_q;
        contend_d   = contend_q;
        cnt_d       = cnt_q;
        for (int b = 0; b < WIDTH; b++) begin
            charge_d[b] = charge_q[b];
            decay_d[b]  = decay_q[b];
        end

        if (in_valid) begin
            out_valid_d = 1'b1;
            contend_d   = bit_contend;
            for (int b = 0; b < WIDTH; b++) begin
                res_val_d[b] = bit_res[b][0];
                res_unk_d[b] = bit_res[b][1];
                if (!bit_allz[b]) begin
                    charge_d[b] = bit_wire[b];
                    decay_d[b]  = '0;
                end else if (decay_q[b] != DECAY_MAX) begin
                    decay_d[b] = decay_q[b] + 1'b1;
                    // Charge is lost on the beat the counter arrives at the limit
                    if (decay_d[b] == DECAY_MAX) begin
                        charge_d[b] = LX;
                    end
                end
            end
        end

        if (cnt_clr) begin
            cnt_d = (in_valid && (|bit_contend)) ? CNT_W'(1) : '0;
        end else if (in_valid && (|bit_contend) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset drops all charge and floats the outputs to z
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_val_q   <= '0;
            res_unk_q   <= '1;
            contend_q   <= '0;
            cnt_q       <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                charge_q[b] <= LX;
                decay_q[b]  <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            res_val_q   <= res_val_d;
            res_unk_q   <= res_unk_d;
            contend_q   <= contend_d;
            cnt_q       <= cnt_d;
            for (int b = 0; b < WIDTH; b++) begin
                charge_q[b] <= charge_d[b];
                decay_q[b]  <= decay_d[b];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign res_val     = res_val_q;
    assign res_unk     = res_unk_q;
    assign contend     = contend_q;
    assign contend_cnt = cnt_q;

endmodule
